// File: rtl/neq_bist_ctrl.sv
// Exhaustive self-test sequencer for a WIDTH-bit inequality comparator.
// Sweeps every (a,b) pair, checks cmp_neq against a != b, and reports the result.

module neq_bist_ctrl #(
   parameter int WIDTH = 6,
   parameter int ERR_W = 2*WIDTH+1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop_on_err,
   input  logic             cmp_neq,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] OPER_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [ERR_W-1:0] r_errCount;
   logic             r_firstValid;
   logic [WIDTH-1:0] r_firstA;
   logic [WIDTH-1:0] r_firstB;
   logic             r_stopOnErr;

   logic             w_mism;
   logic             w_lastVec;
   logic             w_launch;
   logic             w_finish;

   // The comparator is combinational from cmp_a/cmp_b, so the vector on the
   // registered operands is checked in the same cycle it is presented.
   always_comb begin
      w_mism    = (r_state == RUN) && (cmp_neq != (r_a != r_b));
      w_lastVec = (r_a == '1) && (r_b == '1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A sweep ends after the all-ones vector, or early on the first mismatch
   // when the stop-on-error mode was latched at launch.
   always_comb begin
      w_nextState = r_state;
      w_launch    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_launch    = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_lastVec || (w_mism && r_stopOnErr)) begin
               w_finish    = 1'b1;
               w_nextState = DONE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operands advance b-inner/a-outer; they freeze on the final checked vector
   // so the stopping point stays visible in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a          <= '0;
         r_b          <= '0;
         r_errCount   <= '0;
         r_firstValid <= 1'b0;
         r_firstA     <= '0;
         r_firstB     <= '0;
         r_stopOnErr  <= 1'b0;
      end else if (w_launch) begin
         r_a          <= '0;
         r_b          <= '0;
         r_errCount   <= '0;
         r_firstValid <= 1'b0;
         r_firstA     <= '0;
         r_firstB     <= '0;
         r_stopOnErr  <= stop_on_err;
      end else if (r_state == RUN) begin
         if (w_mism) begin
            if (r_errCount != '1) begin
               r_errCount <= r_errCount + ERR_ONE;
            end
            if (!r_firstValid) begin
               r_firstValid <= 1'b1;
               r_firstA     <= r_a;
               r_firstB     <= r_b;
            end
         end
         if (!w_finish) begin
            r_b <= r_b + OPER_ONE;
            if (r_b == '1) begin
               r_a <= r_a + OPER_ONE;
            end
         end
      end
   end

   assign cmp_a           = r_a;
   assign cmp_b           = r_b;
   assign busy            = (r_state == RUN);
   assign done            = (r_state == DONE);
   assign pass            = (r_state == DONE) && (r_errCount == '0);
   assign err_count       = r_errCount;
   assign first_err_valid = r_firstValid;
   assign first_err_a     = r_firstA;
   assign first_err_b     = r_firstB;

endmodule
